// File: rtl/spi_capture_ring.sv
// rtl/spi_capture_ring.sv - timestamped capture ring for SPI receiver words with a 64-bit register read port
module spi_capture_ring #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_InputBuffer,
    input  logic              io_BufferChanged,
    input  logic [6:0]        io_Avalon_address,
    input  logic              io_Avalon_read,
    input  logic              io_Avalon_write,
    input  logic [63:0]       io_Avalon_writedata,
    output logic [63:0]       io_Avalon_readdata,
    output logic              io_Avalon_readdatavalid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [6:0]    DEPTH_7 = 7'(DEPTH);

    localparam logic [6:0] ADDR_STATUS  = 7'h00;
    localparam logic [6:0] ADDR_TOTAL   = 7'h01;
    localparam logic [6:0] ADDR_CONTROL = 7'h02;

    // Synchroniser chain and edge detector state
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    // Ring bookkeeping
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] oldest_q, oldest_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   total_q, total_d;
    logic [15:0]   cycle_q, cycle_d;
    logic          enable_q, enable_d;
    logic          mode_q, mode_d;

    // Read port registers
    logic [63:0] readdata_q, readdata_d;
    logic        rdvalid_q, rdvalid_d;

    // Ring storage (not reset; validity comes from count)
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [15:0]       ts_mem   [DEPTH];

    logic          capture_evt;
    logic          full;
    logic          ctrl_wr;
    logic          do_clear;
    logic          mem_we;
    logic [6:0]    count7;
    logic [6:0]    entry_k;
    logic [AW-1:0] entry_idx;
    logic [63:0]   rd_word;
    logic          unused_wdata;

    assign unused_wdata = ^io_Avalon_writedata[63:3];

    assign capture_evt = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign full        = (count_q == DEPTH_C);
    assign count7      = 7'(count_q);
    assign ctrl_wr     = io_Avalon_write && (io_Avalon_address == ADDR_CONTROL);
    assign do_clear    = ctrl_wr && io_Avalon_writedata[0];
    assign entry_k     = {1'b0, io_Avalon_address[5:0]};
    assign entry_idx   = oldest_q + entry_k[AW-1:0];

    // Next-state for synchroniser, counters, ring pointers and control
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], io_BufferChanged};
        edge_d     = sync_q[SYNC_STAGES-1];
        cycle_d    = cycle_q + 16'd1;
        wr_ptr_d   = wr_ptr_q;
        oldest_d   = oldest_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        total_d    = total_q;
        enable_d   = enable_q;
        mode_d     = mode_q;
        mem_we     = 1'b0;

        if (ctrl_wr) begin
            mode_d   = io_Avalon_writedata[1];
            enable_d = io_Avalon_writedata[2];
        end

        if (do_clear) begin
            // Clear takes priority: a coincident capture is neither stored nor counted
            wr_ptr_d   = '0;
            oldest_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            total_d    = '0;
        end else if (capture_evt && enable_q) begin
            if (total_q != 32'hFFFF_FFFF) begin
                total_d = total_q + 32'd1;
            end
            if (!full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end else if (!mode_q) begin
                // Full ring, wrap mode: write slot equals oldest slot, so both advance
                mem_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                oldest_d   = oldest_q + 1'b1;
                overflow_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Read decode from pre-update state
    always_comb begin
        rd_word = '0;
        if (io_Avalon_address[6]) begin
            if ((entry_k < DEPTH_7) && (entry_k < count7)) begin
                rd_word[DATA_W-1:0] = data_mem[entry_idx];
                rd_word[47:32]      = ts_mem[entry_idx];
                rd_word[63]         = 1'b1;
            end
        end else begin
            case (io_Avalon_address)
                ADDR_STATUS:  rd_word[8:0] = {overflow_q, full, count7};
                ADDR_TOTAL:   rd_word[31:0] = total_q;
                ADDR_CONTROL: rd_word[2:0] = {enable_q, mode_q, 1'b0};
                default:      rd_word = '0;
            endcase
        end
    end

    // Read response: one-cycle latency, data held until the next read
    always_comb begin
        readdata_d = readdata_q;
        rdvalid_d  = 1'b0;
        if (io_Avalon_read) begin
            readdata_d = rd_word;
            rdvalid_d  = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            cycle_q    <= '0;
            wr_ptr_q   <= '0;
            oldest_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
            enable_q   <= 1'b1;
            mode_q     <= 1'b0;
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            oldest_q   <= oldest_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            total_q    <= total_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            rdvalid_q  <= rdvalid_d;
        end
    end

    // Ring storage write; the input word is sampled in the capture cycle
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            data_mem[wr_ptr_q] <= io_InputBuffer;
            ts_mem[wr_ptr_q]   <= cycle_q;
        end
    end

    assign io_Avalon_readdata      = readdata_q;
    assign io_Avalon_readdatavalid = rdvalid_q;

endmodule

// File: tb/tb_spi_capture_ring.sv
// tb/tb_spi_capture_ring.sv - directed self-checking bench for spi_capture_ring
module tb_spi_capture_ring;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  io_InputBuffer;
    logic        io_BufferChanged;
    logic [6:0]  io_Avalon_address;
    logic        io_Avalon_read;
    logic        io_Avalon_write;
    logic [63:0] io_Avalon_writedata;
    logic [63:0] io_Avalon_readdata;
    logic        io_Avalon_readdatavalid;

    int total_cnt = 0;
    int bad_cnt   = 0;

    localparam logic [63:0] M_DV  = 64'h8000_0000_0000_00FF;
    localparam logic [63:0] M_PAD = 64'h7FFF_0000_FFFF_FF00;

    spi_capture_ring #(.DATA_W(8), .DEPTH(64), .SYNC_STAGES(2)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_InputBuffer          (io_InputBuffer),
        .io_BufferChanged        (io_BufferChanged),
        .io_Avalon_address       (io_Avalon_address),
        .io_Avalon_read          (io_Avalon_read),
        .io_Avalon_write         (io_Avalon_write),
        .io_Avalon_writedata     (io_Avalon_writedata),
        .io_Avalon_readdata      (io_Avalon_readdata),
        .io_Avalon_readdatavalid (io_Avalon_readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [63:0] d);
        @(negedge clock);
        io_Avalon_address = a;
        io_Avalon_read    = 1'b1;
        @(negedge clock);
        io_Avalon_read = 1'b0;
        chk("rdvalid", {63'd0, io_Avalon_readdatavalid}, 64'd1);
        d = io_Avalon_readdata;
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] v);
        @(negedge clock);
        io_Avalon_address   = a;
        io_Avalon_writedata = v;
        io_Avalon_write     = 1'b1;
        @(negedge clock);
        io_Avalon_write = 1'b0;
    endtask

    // One receiver word: level high for hi cycles then low; start-to-start spacing is hi+5
    task automatic pulse(input logic [7:0] v, input int hi);
        @(negedge clock);
        io_InputBuffer   = v;
        io_BufferChanged = 1'b1;
        repeat (hi) @(negedge clock);
        io_BufferChanged = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    logic [63:0] d, d0, d1;
    logic [7:0]  vals [4];
    logic [63:0] exp_bb [10];

    initial begin
        reset               = 1'b1;
        io_InputBuffer      = '0;
        io_BufferChanged    = 1'b0;
        io_Avalon_address   = '0;
        io_Avalon_read      = 1'b0;
        io_Avalon_write     = 1'b0;
        io_Avalon_writedata = '0;
        vals[0] = 8'h7A; vals[1] = 8'h80; vals[2] = 8'h0C; vals[3] = 8'h40;

        // Reset state
        do_reset();
        chk("rst_rdata", io_Avalon_readdata, 64'd0);
        chk("rst_rdv", {63'd0, io_Avalon_readdatavalid}, 64'd0);
        rd(7'h00, d); chk("rst_status", d, 64'h0);
        rd(7'h01, d); chk("rst_total", d, 64'h0);
        rd(7'h02, d); chk("rst_ctrl", d, 64'h4);
        rd(7'h40, d); chk("rst_entry0", d, 64'h0);

        // Four words
        for (int i = 0; i < 4; i++) pulse(vals[i], 4);
        rd(7'h00, d); chk("four_status", d, 64'h004);
        for (int i = 0; i < 4; i++) begin
            rd(7'h40 + 7'(i), d);
            chk("four_entry", d & M_DV, {1'b1, 55'd0, vals[i]});
            chk("four_pad", d & M_PAD, 64'd0);
        end
        rd(7'h40, d0);
        rd(7'h41, d1);
        chk("ts_delta", {48'd0, d1[47:32] - d0[47:32]}, 64'd9);
        repeat (3) @(negedge clock);
        chk("rdata_hold", io_Avalon_readdata, d1);
        rd(7'h44, d); chk("four_empty", d, 64'h0);
        rd(7'h01, d); chk("four_total", d, 64'd4);

        // Wrap mode, 70 words
        do_reset();
        for (int i = 0; i < 70; i++) pulse(8'(i), 4);
        rd(7'h00, d); chk("wrap_status", d, 64'h1C0);
        rd(7'h40, d); chk("wrap_first", d & M_DV, {1'b1, 55'd0, 8'd6});
        rd(7'h7F, d); chk("wrap_last", d & M_DV, {1'b1, 55'd0, 8'd69});
        rd(7'h01, d); chk("wrap_total", d, 64'd70);
        rd(7'h3F, d); chk("hole_3f", d, 64'h0);

        // Stop mode, 70 words
        do_reset();
        wr(7'h02, 64'h6);
        rd(7'h02, d); chk("stop_ctrl", d, 64'h6);
        for (int i = 0; i < 70; i++) pulse(8'(i), 4);
        rd(7'h00, d); chk("stop_status", d, 64'h1C0);
        rd(7'h40, d); chk("stop_first", d & M_DV, {1'b1, 55'd0, 8'd0});
        rd(7'h7F, d); chk("stop_last", d & M_DV, {1'b1, 55'd0, 8'd63});
        rd(7'h01, d); chk("stop_total", d, 64'd70);

        // Clear coincident with a capture
        do_reset();
        pulse(8'h11, 4);
        rd(7'h00, d); chk("pre_clr_status", d, 64'h001);
        @(negedge clock);
        io_InputBuffer   = 8'h22;
        io_BufferChanged = 1'b1;
        @(negedge clock);
        @(negedge clock);
        io_Avalon_address   = 7'h02;
        io_Avalon_writedata = 64'h5;
        io_Avalon_write     = 1'b1;
        @(negedge clock);
        io_Avalon_write = 1'b0;
        repeat (2) @(negedge clock);
        io_BufferChanged = 1'b0;
        repeat (4) @(negedge clock);
        rd(7'h00, d); chk("clr_status", d, 64'h0);
        rd(7'h01, d); chk("clr_total", d, 64'h0);
        rd(7'h40, d); chk("clr_entry", d, 64'h0);

        // Disabled captures ignored, long level counts once
        wr(7'h02, 64'h0);
        for (int i = 0; i < 3; i++) pulse(8'h33, 4);
        rd(7'h00, d); chk("dis_status", d, 64'h0);
        rd(7'h01, d); chk("dis_total", d, 64'h0);
        wr(7'h02, 64'h4);
        pulse(8'h5C, 10);
        rd(7'h00, d); chk("long_status", d, 64'h001);
        rd(7'h01, d); chk("long_total", d, 64'd1);
        rd(7'h40, d); chk("long_entry", d & M_DV, {1'b1, 55'd0, 8'h5C});

        // Back-to-back reads, reset in the middle
        exp_bb[0] = 64'h001; exp_bb[1] = 64'd1; exp_bb[2] = 64'h4;
        for (int i = 3; i < 10; i++) exp_bb[i] = 64'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i > 0) begin
                chk("bb_rdv", {63'd0, io_Avalon_readdatavalid}, 64'd1);
                chk("bb_data", io_Avalon_readdata, exp_bb[i-1]);
            end
            io_Avalon_address = 7'(i);
            io_Avalon_read    = 1'b1;
        end
        @(negedge clock);
        chk("bb_rdv_last", {63'd0, io_Avalon_readdatavalid}, 64'd1);
        chk("bb_data_last", io_Avalon_readdata, exp_bb[9]);
        io_Avalon_address = 7'h00;
        reset = 1'b1;
        @(negedge clock);
        chk("bb_rst_rdv", {63'd0, io_Avalon_readdatavalid}, 64'd0);
        chk("bb_rst_rdata", io_Avalon_readdata, 64'd0);
        io_Avalon_read = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("bb_post_rdv", {63'd0, io_Avalon_readdatavalid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/spi_capture_ring.md
SPI_CAPTURE_RING -- requirements
Module: spi_capture_ring

Interface
REQ-001 Parameter DATA_W, default 8, width of each captured SPI byte/word (1..32).
REQ-002 Parameter DEPTH, default 64, ring entries; power of two, 2..64.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flops on io_BufferChanged (2..3).
REQ-004 Port clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port io_InputBuffer  in  DATA_W  data word from the SPI receiver; stable while io_BufferChanged is high.
REQ-007 Port io_BufferChanged  in  1  receiver "new word" level; asynchronous to clock.
REQ-008 Port io_Avalon_address  in  7  word address.
REQ-009 Port io_Avalon_read  in  1  read request.
REQ-010 Port io_Avalon_write  in  1  write request.
REQ-011 Port io_Avalon_writedata  in  64  write data.
REQ-012 Port io_Avalon_readdata  out  64  read data, registered.
REQ-013 Port io_Avalon_readdatavalid  out  1  one-cycle pulse qualifying io_Avalon_readdata.

Function
REQ-014 io_BufferChanged shall pass through SYNC_STAGES flops; a capture event is a 0->1 transition at the synchroniser output.
REQ-015 On a capture event with enable=1, io_InputBuffer shall be sampled in the same cycle and written to the ring at wr_ptr with a 16-bit timestamp equal to the free-running cycle counter.
REQ-016 Free-running cycle counter: 16 bits, increments every cycle, wraps 0xFFFF->0x0000.
REQ-017 count ranges 0..DEPTH; empty = (count==0); full = (count==DEPTH).
REQ-018 Capture when not full: write entry, wr_ptr+1 modulo DEPTH, count+1.
REQ-019 Capture when full, mode=0 (wrap): overwrite oldest entry, advance both wr_ptr and oldest pointer, count stays DEPTH, overflow set.
REQ-020 Capture when full, mode=1 (stop): entry dropped, ring unchanged, overflow set.
REQ-021 total: 32-bit counter of every capture event while enable=1 (stored or dropped), saturating at 0xFFFFFFFF.
REQ-022 Capture events while enable=0 shall be ignored entirely, including by total.
REQ-023 Register map (read): 0x00 status = {overflow[8], full[7], count[6:0]}, zero elsewhere; 0x01 total zero-extended; 0x02 control = {enable[2], mode[1], 0[0]}; 0x03..0x3F read 0.
REQ-024 Read 0x40+k, k<DEPTH: entry k counted from oldest; bits[DATA_W-1:0] data, [47:32] timestamp, [63] valid = (k<count); all other bits 0; if k>=count, whole word 0.
REQ-025 Addresses 0x40+k with k>=DEPTH shall read 0.
REQ-026 Read latency exactly 1 cycle: readdatavalid pulses the cycle after io_Avalon_read=1; readdata holds its value until the next read.
REQ-027 Read data shall reflect state before any capture or write in the request cycle.
REQ-028 Write 0x02: bit0=1 clears ring (pointers, count, overflow, total to 0); bit1 -> mode; bit2 -> enable. Writes elsewhere ignored.
REQ-029 Clear and capture in the same cycle: clear wins, capture dropped and not counted.
REQ-030 Simultaneous read and write: both performed; read returns pre-write values.
REQ-031 No wait-request; every read and write completes in the request cycle.

Reset
REQ-032 While reset=1 at a clock edge: pointers, count, overflow, total, cycle counter, synchroniser flops, readdata, readdatavalid = 0; enable=1; mode=0; ring contents undefined but reported invalid.
REQ-033 Reset asserted mid-capture or mid-read shall abort it; no readdatavalid pulse after reset.
REQ-034 First capture event recognisable SYNC_STAGES+1 cycles after reset deassertion with io_BufferChanged rising.

Verification
REQ-035 After reset, write bytes 0x7A, 0x80, 0x0C, 0x40 via pulses -> status reads 0x004; 0x40..0x43 read data 0x7A,0x80,0x0C,0x40 with bit63=1; 0x44 reads 0.
REQ-036 DEPTH=64, mode=0, 70 captures of values 0..69 -> status 0x1C0 (overflow, full, count 64); 0x40 reads data 6; 0x7F reads data 69; total=70.
REQ-037 Same with mode=1 -> 0x40 reads 0, 0x7F reads 63, overflow=1, total=70.
REQ-038 Write 0x02 value 0x5 coincident with capture event -> status 0, total 0, captured byte absent.
REQ-039 Write control enable=0, send 3 captures -> count and total unchanged; io_BufferChanged held high for 10 cycles counts as one capture.
REQ-040 Read back-to-back every cycle across addresses 0..9 -> readdatavalid high every cycle, data one cycle late; reset asserted mid-sequence -> readdatavalid 0 the next cycle.
